// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - register-programmed two-channel duty-level fader for a pair of PWM generators
module pwm_fade_ctrl #(
    parameter int DUTY_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  strobe,
    input  logic [3:0]            address,
    input  logic                  data_write,
    input  logic [DUTY_WIDTH-1:0] data_in,
    output logic [DUTY_WIDTH-1:0] data_out,
    output logic [DUTY_WIDTH-1:0] level_0,
    output logic [DUTY_WIDTH-1:0] level_1,
    output logic                  busy,
    output logic                  done
);

    localparam logic [3:0] ADDR_TARGET0 = 4'h0;
    localparam logic [3:0] ADDR_TARGET1 = 4'h1;
    localparam logic [3:0] ADDR_STEP    = 4'h2;
    localparam logic [3:0] ADDR_RATE    = 4'h3;
    localparam logic [3:0] ADDR_CTRL    = 4'h4;
    localparam logic [3:0] ADDR_LEVEL0  = 4'h5;
    localparam logic [3:0] ADDR_LEVEL1  = 4'h6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DUTY_WIDTH-1:0] target0_q;
    logic [DUTY_WIDTH-1:0] target1_q;
    logic [DUTY_WIDTH-1:0] step_q;
    logic [DUTY_WIDTH-1:0] rate_q;
    logic [DUTY_WIDTH-1:0] level0_q, level0_d;
    logic [DUTY_WIDTH-1:0] level1_q, level1_d;
    logic [DUTY_WIDTH-1:0] rate_cnt_q, rate_cnt_d;
    logic                  done_q, done_d;

    logic                  ctrl_wr;
    logic                  start_req;
    logic                  abort_req;
    logic                  clear_req;
    logic [DUTY_WIDTH-1:0] step_eff;
    logic [DUTY_WIDTH-1:0] next0;
    logic [DUTY_WIDTH-1:0] next1;
    logic                  tick;

    // Move one channel at most stp toward tgt; the clamp to tgt keeps it inside 0..max.
    function automatic logic [DUTY_WIDTH-1:0] step_toward(
        input logic [DUTY_WIDTH-1:0] lvl,
        input logic [DUTY_WIDTH-1:0] tgt,
        input logic [DUTY_WIDTH-1:0] stp
    );
        logic [DUTY_WIDTH-1:0] res;
        if (tgt >= lvl) begin
            if ((tgt - lvl) <= stp) res = tgt;
            else                    res = lvl + stp;
        end else begin
            if ((lvl - tgt) <= stp) res = tgt;
            else                    res = lvl - stp;
        end
        return res;
    endfunction

    assign ctrl_wr   = data_write && (address == ADDR_CTRL);
    assign abort_req = ctrl_wr && data_in[1];
    assign start_req = ctrl_wr && data_in[0] && !data_in[1];
    assign clear_req = ctrl_wr && data_in[2];

    assign step_eff = (step_q == '0) ? {{(DUTY_WIDTH-1){1'b0}}, 1'b1} : step_q;
    assign next0    = step_toward(level0_q, target0_q, step_eff);
    assign next1    = step_toward(level1_q, target1_q, step_eff);
    assign tick     = (state_q == RAMP) && strobe && !abort_req && (rate_cnt_q == rate_q);

    always_comb begin
        state_d    = state_q;
        level0_d   = level0_q;
        level1_d   = level1_q;
        rate_cnt_d = rate_cnt_q;
        done_d     = done_q;

        if (clear_req) done_d = 1'b0;

        case (state_q)
            IDLE: begin
                rate_cnt_d = '0;
                if (data_write && address == ADDR_LEVEL0) level0_d = data_in;
                if (data_write && address == ADDR_LEVEL1) level1_d = data_in;
                if (start_req) begin
                    if (level0_q == target0_q && level1_q == target1_q) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (abort_req) begin
                    state_d    = IDLE;
                    rate_cnt_d = '0;
                end else if (tick) begin
                    rate_cnt_d = '0;
                    level0_d   = next0;
                    level1_d   = next1;
                    // Completion overrides a clear-done arriving in the same cycle.
                    if (next0 == target0_q && next1 == target1_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (strobe) begin
                    rate_cnt_d = rate_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target0_q  <= '0;
            target1_q  <= '0;
            step_q     <= '0;
            rate_q     <= '0;
            level0_q   <= '0;
            level1_q   <= '0;
            rate_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level0_q   <= level0_d;
            level1_q   <= level1_d;
            rate_cnt_q <= rate_cnt_d;
            done_q     <= done_d;
            if (data_write) begin
                case (address)
                    ADDR_TARGET0: target0_q <= data_in;
                    ADDR_TARGET1: target1_q <= data_in;
                    ADDR_STEP:    step_q    <= data_in;
                    ADDR_RATE:    rate_q    <= data_in;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_TARGET0: data_out = target0_q;
            ADDR_TARGET1: data_out = target1_q;
            ADDR_STEP:    data_out = step_q;
            ADDR_RATE:    data_out = rate_q;
            ADDR_CTRL:    data_out = {{(DUTY_WIDTH-3){1'b0}}, done_q, 1'b0, busy};
            ADDR_LEVEL0:  data_out = level0_q;
            ADDR_LEVEL1:  data_out = level1_q;
            default:      data_out = '0;
        endcase
    end

    assign busy    = (state_q == RAMP);
    assign done    = done_q;
    assign level_0 = level0_q;
    assign level_1 = level1_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - directed self-checking bench for pwm_fade_ctrl
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       strobe;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] level_0;
    logic [7:0] level_1;
    logic       busy;
    logic       done;

    int err_cnt = 0;
    int chk_cnt = 0;

    pwm_fade_ctrl #(.DUTY_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .strobe     (strobe),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .level_0    (level_0),
        .level_1    (level_1),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [7:0] data);
        address    = addr;
        data_in    = data;
        data_write = 1'b1;
        tick_clk();
        data_write = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic pulse_strobe();
        strobe = 1'b1;
        tick_clk();
        strobe = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] addr, output int unsigned val);
        address = addr;
        #1;
        val = data_out;
    endtask

    int unsigned rd;
    int unsigned exp_l0;

    initial begin
        rst_n      = 1'b0;
        strobe     = 1'b0;
        address    = 4'h0;
        data_write = 1'b0;
        data_in    = 8'h00;
        tick_clk();
        tick_clk();
        rst_n = 1'b1;

        // Reset state
        check("rst_level0", level_0, 0);
        check("rst_level1", level_1, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        for (int a = 0; a < 16; a++) begin
            reg_read(a[3:0], rd);
            check($sformatf("rst_rd_%0d", a), rd, 0);
        end

        // Basic ramp: 30,60,90,100
        reg_write(4'h0, 8'd100);
        reg_write(4'h1, 8'd0);
        reg_write(4'h2, 8'd30);
        reg_write(4'h3, 8'd0);
        reg_write(4'h4, 8'h01);
        check("ramp_busy", busy, 1);
        check("ramp_done0", done, 0);
        pulse_strobe();
        check("ramp_s1", level_0, 30);
        tick_clk();
        check("ramp_hold", level_0, 30);
        pulse_strobe();
        check("ramp_s2", level_0, 60);
        pulse_strobe();
        check("ramp_s3", level_0, 90);
        check("ramp_busy3", busy, 1);
        pulse_strobe();
        check("ramp_s4", level_0, 100);
        check("ramp_l1", level_1, 0);
        check("ramp_end_busy", busy, 0);
        check("ramp_end_done", done, 1);
        reg_read(4'h4, rd);
        check("ramp_ctrl_rd", rd, 8'h04);

        // Clear-done, then start with levels already at target
        reg_write(4'h4, 8'h04);
        check("clr_done", done, 0);
        reg_write(4'h4, 8'h01);
        check("eq_busy", busy, 0);
        check("eq_done", done, 1);

        // Slow decrement with STEP=0, RATE=2
        reg_write(4'h5, 8'd200);
        check("ld_level0", level_0, 200);
        reg_write(4'h0, 8'd10);
        reg_write(4'h2, 8'd0);
        reg_write(4'h3, 8'd2);
        reg_write(4'h4, 8'h01);
        check("slow_busy", busy, 1);
        check("slow_done", done, 0);
        for (int k = 1; k <= 570; k++) begin
            pulse_strobe();
            exp_l0 = 200 - (k / 3);
            check($sformatf("slow_k%0d", k), level_0, exp_l0);
        end
        check("slow_end_busy", busy, 0);
        check("slow_end_done", done, 1);
        pulse_strobe();
        check("slow_idle_strobe", level_0, 10);

        // Target rewrite mid-ramp, ignored LEVEL write, start+abort
        reg_write(4'h0, 8'd200);
        reg_write(4'h1, 8'd255);
        reg_write(4'h2, 8'd50);
        reg_write(4'h3, 8'd1);
        reg_write(4'h4, 8'h01);
        pulse_strobe();
        check("rev_cnt_l0", level_0, 10);
        pulse_strobe();
        check("rev_t1_l0", level_0, 60);
        check("rev_t1_l1", level_1, 50);
        pulse_strobe();
        pulse_strobe();
        check("rev_t2_l0", level_0, 110);
        check("rev_t2_l1", level_1, 100);
        reg_write(4'h0, 8'd20);
        pulse_strobe();
        pulse_strobe();
        check("rev_down_l0", level_0, 60);
        check("rev_up_l1", level_1, 150);
        reg_write(4'h5, 8'd5);
        check("ramp_lvl_wr_ign", level_0, 60);
        reg_write(4'h4, 8'h03);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_l0", level_0, 60);
        check("abort_l1", level_1, 150);
        pulse_strobe();
        check("abort_frozen", level_0, 60);
        reg_write(4'h5, 8'd33);
        check("abort_ld_l0", level_0, 33);
        reg_read(4'h5, rd);
        check("rd_level0", rd, 33);
        reg_read(4'h2, rd);
        check("rd_step", rd, 50);
        reg_read(4'h7, rd);
        check("rd_unmapped", rd, 0);

        // Reset mid-ramp
        reg_write(4'h0, 8'd200);
        reg_write(4'h1, 8'd0);
        reg_write(4'h2, 8'd10);
        reg_write(4'h3, 8'd0);
        reg_write(4'h4, 8'h01);
        pulse_strobe();
        check("pre_rst_l0", level_0, 43);
        check("pre_rst_l1", level_1, 140);
        rst_n = 1'b0;
        tick_clk();
        rst_n = 1'b1;
        check("mid_rst_l0", level_0, 0);
        check("mid_rst_l1", level_1, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        reg_read(4'h0, rd);
        check("mid_rst_tgt0", rd, 0);
        pulse_strobe();
        pulse_strobe();
        check("post_rst_l0", level_0, 0);
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 The block SHALL have parameter DUTY_WIDTH, default 8, the width of the duty levels and register data.
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port strobe, input, 1, a one-cycle PWM period strobe from the strobe generator.
REQ-005 The block SHALL have port address, input, 4, the register address.
REQ-006 The block SHALL have port data_write, input, 1, the write request, qualifying data_in in the same cycle.
REQ-007 The block SHALL have port data_in, input, 8, the write data.
REQ-008 The block SHALL have port data_out, output, 8, combinational read data for the current address.
REQ-009 The block SHALL have ports level_0 and level_1, output, 8 each, the duty levels driven into the two PWM generators.
REQ-010 The block SHALL have port busy, output, 1, high while the FSM is in RAMP.
REQ-011 The block SHALL have port done, output, 1, a sticky fade-complete flag.

Function
REQ-012 The register map SHALL be as follows, with every other address reading 0 and ignoring writes:
- 0x0 TARGET0, read/write.
- 0x1 TARGET1, read/write.
- 0x2 STEP, read/write.
- 0x3 RATE, read/write.
- 0x4 CTRL: write bit0 = start, bit1 = abort, bit2 = clear done; read = {5'b0, done, 1'b0, busy}.
- 0x5 LEVEL0, read/write.
- 0x6 LEVEL1, read/write.
REQ-013 The FSM SHALL have two states, IDLE and RAMP, and busy SHALL equal (state == RAMP).
REQ-014 A CTRL write with start=1 and abort=0 in IDLE SHALL clear done, clear the rate counter and enter RAMP on the next cycle, unless both levels already equal their targets.
REQ-015 If both levels already equal their targets at start, the FSM SHALL stay in IDLE and set done on the next cycle.
REQ-016 In RAMP, a tick SHALL occur on a strobe cycle when the rate counter equals RATE, at which point the counter resets to 0.
REQ-017 On a strobe cycle without a tick, the rate counter SHALL increment; RATE=N therefore gives one step per N+1 strobes.
REQ-018 On a tick, each channel SHALL update independently: if |target-level| <= STEP_eff then level = target, otherwise level moves STEP_eff toward target.
REQ-019 STEP_eff SHALL be max(STEP,1), so STEP=0 behaves as STEP=1.
REQ-020 Level arithmetic SHALL never wrap past 0 or 255.
REQ-021 When both levels equal their targets after a tick, the FSM SHALL return to IDLE and set done in the same edge.
REQ-022 A TARGET write during RAMP SHALL take effect at the next tick, and the ramp may reverse direction as a result.
REQ-023 A LEVEL write in IDLE SHALL load level_x directly; a LEVEL write during RAMP SHALL be ignored.
REQ-024 Abort (CTRL bit1=1) SHALL force IDLE on the next cycle, freeze both levels and leave done unchanged; if start and abort are written together, abort SHALL win.
REQ-025 A start write during RAMP SHALL be ignored.
REQ-026 done SHALL be cleared by start or by clear-done (bit2); if clear-done and completion occur in the same cycle, completion SHALL win.
REQ-027 strobe SHALL be ignored in IDLE, and the rate counter SHALL hold 0 in IDLE.
REQ-028 level_0 and level_1 SHALL be registered outputs that change only on the clock edge after a tick or a LEVEL write.

Reset
REQ-029 With rst_n low at a clock edge, all registers, both levels, the rate counter and done SHALL become 0 and the FSM SHALL enter IDLE; this applies mid-RAMP too.
REQ-030 After reset, level_0=0, level_1=0, busy=0, done=0 and data_out=0 for every address.

Verification
REQ-031 TARGET0=100, TARGET1=0, STEP=30, RATE=0, then start -> level_0 steps 30,60,90,100 on four consecutive strobes, then busy=0 and done=1.
REQ-032 LEVEL0=200 in IDLE, TARGET0=10, STEP=0, RATE=2, then start -> level_0 decrements by 1 every 3rd strobe and reaches 10 after 190 ticks, with no wrap.
REQ-033 Start with levels equal to targets -> busy stays 0 and done=1 one cycle later.
REQ-034 Mid-ramp CTRL=0x03 (start+abort) -> IDLE on the next cycle, levels frozen, done=0; a LEVEL0 write then loads directly.
REQ-035 Mid-ramp TARGET0 is rewritten below the current level -> the next tick moves level_0 downward.
REQ-036 rst_n is held low for one cycle mid-ramp -> all outputs are 0 and busy=0 on the following cycle, and later strobes cause no change.
